// File: rtl/conv1d_pkg.sv
// conv1d_pkg: opcodes, FSM states, status bit positions and rw_at_once legality shared by the conv1d engine.
package conv1d_pkg;

    typedef enum logic [6:0] {
        CMD_BUF_SIZE  = 7'd0,
        CMD_WR_INPUT  = 7'd1,
        CMD_WR_FILTER = 7'd2,
        CMD_OFFSET    = 7'd3,
        CMD_DEPTH     = 7'd5,
        CMD_START     = 7'd6,
        CMD_RESULT    = 7'd7,
        CMD_START_X   = 7'd8,
        CMD_STATUS    = 7'd9,
        CMD_RD_INPUT  = 7'd10,
        CMD_RD_FILTER = 7'd11,
        CMD_RW        = 7'd18,
        CMD_ACC       = 7'd19,
        CMD_CLR_ERR   = 7'd20
    } cmd_e;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_QUANT} fsm_state_t;

    localparam int ST_DONE = 0;
    localparam int ST_ERR  = 1;
    localparam int ST_BUSY = 2;

    function automatic logic rw_legal(input logic [31:0] v);
        return v == 32'd1 || v == 32'd2 || v == 32'd4;
    endfunction

endpackage

// File: rtl/conv1d_mac_lanes.sv
// conv1d_mac_lanes: LANES signed byte products summed and registered as one partial sum (pipeline stage 1).
module conv1d_mac_lanes
    import conv1d_pkg::*;
#(
    parameter int LANES     = 8,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic                 valid_i,
    input  logic [LANES*8-1:0]   filt_i,
    input  logic [LANES*8-1:0]   inp_i,
    input  logic [ACC_WIDTH-1:0] offset_i,
    output logic [ACC_WIDTH-1:0] sum_o,
    output logic                 valid_o
);

    logic [ACC_WIDTH-1:0] sum_q, sum_d;
    logic                 valid_q;

    always_comb begin
        sum_d = '0;
        for (int j = 0; j < LANES; j++)
            sum_d = sum_d + ACC_WIDTH'($signed(filt_i[8*j+:8])) * (ACC_WIDTH'($signed(inp_i[8*j+:8])) + offset_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
        end else if (en_i) begin
            sum_q   <= sum_d;
            valid_q <= valid_i;
        end
    end

    assign sum_o   = sum_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/conv1d_mac_engine.sv
// conv1d_mac_engine: 1-D convolution CFU datapath with byte-packed ring/filter buffers and a LANES-wide MAC.
// Define CONV1D_READBACK_EN to enable buffer readback through commands 10/11.
module conv1d_mac_engine
    import conv1d_pkg::*;
#(
    parameter int LANES              = 8,
    parameter int KERNEL_LENGTH      = 8,
    parameter int MAX_INPUT_CHANNELS = 128,
    parameter int ACC_WIDTH          = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [6:0]           cmd,
    input  logic [31:0]          inp0,
    input  logic [31:0]          inp1,
    output logic [31:0]          ret,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 quant_start,
    input  logic                 quant_done,
    input  logic [31:0]          quant_result,
    output logic                 busy
);

    localparam int BUF_SIZE = KERNEL_LENGTH * MAX_INPUT_CHANNELS;
    localparam int IW = $clog2(BUF_SIZE);
    localparam int AW = IW + 1;
    localparam int DW = $clog2(MAX_INPUT_CHANNELS + 1);
    localparam int SW = $clog2(KERNEL_LENGTH + 1);

    logic [7:0] in_buf   [BUF_SIZE];
    logic [7:0] filt_buf [BUF_SIZE];

    fsm_state_t           state_q, state_d;
    logic [AW-1:0]        k_q, k_d, x_q, x_d, cur, xj, xn, kn;
    logic [ACC_WIDTH-1:0] acc_q, acc_d, sum1;
    logic [31:0]          ret_q, ret_d, quant_q, quant_d, offset_q, offset_d;
    logic [DW-1:0]        depth_q, depth_d;
    logic [SW-1:0]        sx_q, sx_d;
    logic [2:0]           rw_q, rw_d;
    logic                 busy_q, busy_d, done_q, done_d, err_q, err_d, qs_q, qs_d, drain_q, drain_d, v1;
    logic [3:0]           we_in, we_f, in_rng, rw_mask;
    logic [IW-1:0]        ba [4];
    logic [LANES*8-1:0]   lane_inp, lane_filt;

    assign cur     = AW'(KERNEL_LENGTH) * AW'(depth_q);
    assign xn      = x_q + AW'(LANES);
    assign kn      = k_q + AW'(LANES);
    assign rw_mask = rw_q == 3'd4 ? 4'hf : rw_q == 3'd2 ? 4'h3 : 4'h1;

    // Bytes past the end of the buffer are dropped rather than wrapped.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            in_rng[i] = ({1'b0, inp0} + 33'(i)) < 33'(BUF_SIZE);
            ba[i]     = inp0[IW-1:0] + IW'(i);
        end
    end

    // The ring wrap is applied per lane so a beat may straddle the end of the current window.
    always_comb begin
        xj = '0;
        for (int j = 0; j < LANES; j++) begin
            xj = x_q + AW'(j);
            xj = (xj >= cur) ? xj - cur : xj;
            lane_inp[8*j+:8]  = in_buf[xj[IW-1:0]];
            lane_filt[8*j+:8] = filt_buf[k_q[IW-1:0] + IW'(j)];
        end
    end

    conv1d_mac_lanes #(.LANES(LANES), .ACC_WIDTH(ACC_WIDTH)) u_lanes (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (en),
        .valid_i (state_q == S_MAC),
        .filt_i  (lane_filt),
        .inp_i   (lane_inp),
        .offset_i(ACC_WIDTH'($signed(offset_q))),
        .sum_o   (sum1),
        .valid_o (v1)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        x_d      = x_q;
        drain_d  = drain_q;
        acc_d    = v1 ? acc_q + sum1 : acc_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        quant_d  = quant_q;
        offset_d = offset_q;
        depth_d  = depth_q;
        sx_d     = sx_q;
        rw_d     = rw_q;
        qs_d     = 1'b0;
        ret_d    = '0;
        we_in    = '0;
        we_f     = '0;
        case (state_q)
            S_MAC: begin
                k_d = kn;
                x_d = (xn >= cur) ? xn - cur : xn;
                if (kn >= cur) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                drain_d = ~drain_q;
                if (drain_q) begin
                    state_d = S_QUANT;
                    qs_d    = 1'b1;
                end
            end
            S_QUANT: if (quant_done) begin
                quant_d = quant_result;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: ;
        endcase
        case (cmd_e'(cmd))
            CMD_BUF_SIZE: ret_d = 32'(BUF_SIZE);
            CMD_WR_INPUT: begin
                we_in = busy_q ? 4'h0 : rw_mask & in_rng;
                err_d = err_q | busy_q | (|(rw_mask & ~in_rng));
            end
            CMD_WR_FILTER: begin
                we_f  = busy_q ? 4'h0 : rw_mask & in_rng;
                err_d = err_q | busy_q | (|(rw_mask & ~in_rng));
            end
            CMD_OFFSET: if (busy_q) err_d = 1'b1; else offset_d = inp1;
            CMD_DEPTH: if (busy_q || inp1 > 32'(MAX_INPUT_CHANNELS)) err_d = 1'b1; else depth_d = DW'(inp1);
            CMD_START_X: if (busy_q || inp1 >= 32'(KERNEL_LENGTH)) err_d = 1'b1; else sx_d = SW'(inp1);
            CMD_START: begin
                if (busy_q || cur % AW'(LANES) != '0) err_d = 1'b1;
                else begin
                    acc_d   = '0;
                    k_d     = '0;
                    x_d     = AW'(sx_q) * AW'(depth_q);
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = cur == '0 ? S_DRAIN : S_MAC;
                end
            end
            CMD_RESULT: ret_d = quant_q;
            CMD_STATUS: begin
                ret_d[ST_BUSY] = busy_q;
                ret_d[ST_ERR]  = err_q;
                ret_d[ST_DONE] = done_q;
            end
            CMD_RW: if (rw_legal(inp1)) rw_d = inp1[2:0]; else err_d = 1'b1;
            CMD_ACC: ret_d = 32'($signed(acc_q));
            CMD_CLR_ERR: err_d = 1'b0;
`ifdef CONV1D_READBACK_EN
            CMD_RD_INPUT, CMD_RD_FILTER: begin
                for (int i = 0; i < 4; i++)
                    if (rw_mask[i] && in_rng[i])
                        ret_d[8*i+:8] = cmd == CMD_RD_INPUT ? in_buf[ba[i]] : filt_buf[ba[i]];
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            x_q      <= '0;
            drain_q  <= 1'b0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            err_q    <= 1'b0;
            quant_q  <= '0;
            offset_q <= '0;
            depth_q  <= '0;
            sx_q     <= '0;
            rw_q     <= 3'd4;
            qs_q     <= 1'b0;
            ret_q    <= '0;
        end else if (en) begin
            state_q  <= state_d;
            k_q      <= k_d;
            x_q      <= x_d;
            drain_q  <= drain_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            quant_q  <= quant_d;
            offset_q <= offset_d;
            depth_q  <= depth_d;
            sx_q     <= sx_d;
            rw_q     <= rw_d;
            qs_q     <= qs_d;
            ret_q    <= ret_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en && rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (we_in[i]) in_buf[ba[i]] <= inp1[8*i+:8];
                if (we_f[i]) filt_buf[ba[i]] <= inp1[8*i+:8];
            end
        end
    end

    assign ret         = ret_q;
    assign acc         = acc_q;
    assign quant_start = qs_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_conv1d_mac_engine.sv
// tb_conv1d_mac_engine: directed and randomized convolution runs checked against a plain-arithmetic reference.
module tb_conv1d_mac_engine;

    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b1;
    logic [6:0]  cmd = 7'd127;
    logic [31:0] inp0 = '0, inp1 = '0, ret, acc, quant_result = '0;
    logic        quant_start, quant_done = 1'b0, busy;
    int          n_tests = 0, n_fail = 0, q_lat = 0;
    byte         m_in [1024];
    byte         m_filt [1024];
    int          m_depth = 0, m_sx = 0, m_off = 0, m_rw = 4;

    conv1d_mac_engine dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cmd(cmd), .inp0(inp0), .inp1(inp1), .ret(ret), .acc(acc),
        .quant_start(quant_start), .quant_done(quant_done), .quant_result(quant_result), .busy(busy)
    );

    always #5 clk = ~clk;

    // Passthrough quantiser answering q_lat cycles after the start pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (quant_start) begin
                repeat (q_lat) @(negedge clk);
                quant_result = acc;
                quant_done   = 1'b1;
                @(negedge clk);
                quant_done   = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    task automatic issue(input logic [6:0] c, input logic [31:0] a, input logic [31:0] d, output logic [31:0] r);
        @(negedge clk);
        cmd = c; inp0 = a; inp1 = d;
        @(negedge clk);
        r = ret;
        cmd = 7'd127;
    endtask

    task automatic load(input logic [6:0] c, input int nbytes);
        logic [31:0] r, w;
        for (int a = 0; a < nbytes; a += 4) begin
            for (int i = 0; i < 4; i++) w[8*i+:8] = (c == 7'd1) ? m_in[a+i] : m_filt[a+i];
            issue(c, a, w, r);
        end
    endtask

    task automatic wr(input logic [6:0] c, input int a, input logic [31:0] d);
        logic [31:0] r;
        issue(c, a, d, r);
        for (int i = 0; i < m_rw; i++)
            if (a + i < 1024) begin
                if (c == 7'd1) m_in[a+i] = d[8*i+:8];
                else m_filt[a+i] = d[8*i+:8];
            end
    endtask

    task automatic setp(input int d, input int sx, input int off);
        logic [31:0] r;
        issue(7'd5, 0, d, r);
        issue(7'd8, 0, sx, r);
        issue(7'd3, 0, off, r);
        m_depth = d; m_sx = sx; m_off = off;
    endtask

    function automatic logic [31:0] model_acc();
        int s = 0;
        int cur = 8 * m_depth;
        for (int t = 0; t < cur; t++)
            s += int'(m_filt[t]) * (int'(m_in[(m_sx * m_depth + t) % cur]) + m_off);
        return s;
    endfunction

    task automatic wait_idle(input string tag, output int n);
        n = 0;
        while (busy && n < 3000) begin @(negedge clk); n++; end
        check({tag, "_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic go(input string tag, input int q, input int stall, input logic [31:0] exp);
        logic [31:0] r;
        int n;
        q_lat = q;
        issue(7'd6, 0, 0, r);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        if (stall > 0) begin
            en = 1'b0;
            repeat (stall) @(negedge clk);
            en = 1'b1;
        end
        wait_idle(tag, n);
        check({tag, "_lat"}, n + stall, (8 * m_depth) / 8 + 3 + q + stall);
        issue(7'd19, 0, 0, r); check({tag, "_acc"}, r, exp);
        issue(7'd7, 0, 0, r);  check({tag, "_quant"}, r, exp);
    endtask

    initial begin
        logic [31:0] r;
        int n;
        repeat (3) @(negedge clk);
        check("rst_ret", ret, 32'd0);
        check("rst_acc", acc, 32'd0);
        check("rst_qstart", 32'(quant_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        issue(7'd9, 0, 0, r);  check("rst_status", r, 32'd1);
        issue(7'd0, 0, 0, r);  check("buf_size", r, 32'd1024);
        issue(7'd99, 0, 0, r); check("bad_opcode", r, 32'd0);

        for (int i = 0; i < 8; i++) begin m_in[i] = byte'(i + 1); m_filt[i] = 8'sd1; end
        load(7'd1, 8); load(7'd2, 8);
        setp(1, 0, 0);
        go("t1", 0, 0, 32'd36);
        go("t1_q3", 3, 0, 32'd36);

        for (int i = 0; i < 16; i++) begin m_in[i] = -8'sd128; m_filt[i] = 8'sd2; end
        load(7'd1, 16); load(7'd2, 16);
        setp(2, 0, 128);
        go("t2_off128", 1, 0, 32'd0);
        setp(2, 0, 1);
        go("t2_off1", 1, 0, 32'hFFFF_F020);

        for (int i = 0; i < 8; i++) begin m_in[i] = byte'(i + 1); m_filt[i] = (i == 3) ? 8'sd1 : 8'sd0; end
        load(7'd1, 8); load(7'd2, 8);
        setp(1, 5, 0);
        go("t3_wrap", 0, 0, 32'd1);

        q_lat = 20;
        issue(7'd6, 0, 0, r);
        issue(7'd1, 0, 32'h7f7f_7f7f, r);
        issue(7'd9, 0, 0, r); check("t4_busy_status", r, 32'd6);
        issue(7'd6, 0, 0, r);
        issue(7'd3, 0, 32'd77, r);
        wait_idle("t4", n);
        issue(7'd9, 0, 0, r); check("t4_done_status", r, 32'd3);
        issue(7'd20, 0, 0, r);
        issue(7'd9, 0, 0, r); check("t4_clr_status", r, 32'd1);
        go("t4_rerun", 0, 0, 32'd1);

        issue(7'd5, 0, 129, r);
        issue(7'd9, 0, 0, r); check("depth_range_err", r, 32'd3);
        issue(7'd20, 0, 0, r);
        issue(7'd8, 0, 8, r);
        issue(7'd9, 0, 0, r); check("startx_range_err", r, 32'd3);
        issue(7'd20, 0, 0, r);
        go("params_kept", 2, 0, 32'd1);
        setp(0, 0, 5);
        go("depth0", 1, 0, 32'd0);

        for (int it = 0; it < 6; it++) begin
            int d = (it == 5) ? 128 : $urandom_range(1, 16);
            for (int i = 0; i < 8 * d; i++) begin m_in[i] = byte'($urandom); m_filt[i] = byte'($urandom); end
            load(7'd1, 8 * d); load(7'd2, 8 * d);
            setp(d, $urandom_range(0, 7), int'($urandom_range(0, 600)) - 300);
            go($sformatf("rand%0d", it), $urandom_range(0, 3), (it == 2) ? 4 : 0, model_acc());
        end

        issue(7'd18, 0, 2, r); m_rw = 2;
        wr(7'd2, 1023, 32'h4433_2211);
        issue(7'd9, 0, 0, r); check("t5_oob_err", r, 32'd3);
        issue(7'd20, 0, 0, r);
        issue(7'd18, 0, 3, r);
        issue(7'd9, 0, 0, r); check("t5_rw_err", r, 32'd3);
        issue(7'd20, 0, 0, r);
        wr(7'd2, 0, 32'hDDCC_BBAA);
        go("t5_run", 1, 0, model_acc());
        issue(7'd18, 0, 4, r); m_rw = 4;

        q_lat = 0;
        issue(7'd6, 0, 0, r);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_qstart", 32'(quant_start), 32'd0);
        check("t6_acc", acc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_depth = 0; m_sx = 0; m_off = 0; m_rw = 4;
        issue(7'd9, 0, 0, r); check("t6_status", r, 32'd1);
        for (int i = 0; i < 8; i++) begin m_in[i] = byte'(i + 1); m_filt[i] = 8'sd1; end
        load(7'd1, 8); load(7'd2, 8);
        setp(1, 0, 0);
        go("t6_rerun", 2, 0, 32'd36);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
